// File: rtl/load_store_unit.sv
// Load/store unit: turns datapath MemRead/MemWrite requests into a single
// word-aligned bus transaction, with byte lanes, load extension and a timeout.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [2:0]  req_f3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_valid,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    localparam logic [7:0] TIMEOUT_COUNT = 8'(TIMEOUT_CYCLES);

    state_t      state;
    logic [7:0]  cycle_count;
    logic [7:0]  next_count;
    logic [2:0]  f3_q;
    logic [1:0]  lane_q;
    logic        is_load_q;
    logic        request;
    logic        addr_bad;
    logic        accept;
    logic [3:0]  store_be;
    logic [31:0] store_data;
    logic [31:0] shifted;
    logic [31:0] load_ext;

    // Alignment only matters while a new request can be accepted in IDLE.
    always_comb begin
        request = req_read | req_write;
        case (req_f3[1:0])
            2'b01:   addr_bad = req_addr[0];
            2'b10:   addr_bad = (req_addr[1:0] != 2'b00);
            default: addr_bad = 1'b0;
        endcase
        misaligned = (state == IDLE) && request && addr_bad;
        accept     = (state == IDLE) && request && !addr_bad;
        stall      = accept || (state == BUS);
        next_count = cycle_count + 8'd1;
    end

    always_comb begin
        case (req_f3[1:0])
            2'b00: begin
                store_be   = 4'b0001 << req_addr[1:0];
                store_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                store_be   = 4'b0011 << req_addr[1:0];
                store_data = {2{req_wdata[15:0]}};
            end
            default: begin
                store_be   = 4'b1111;
                store_data = req_wdata;
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 before extending it.
    always_comb begin
        shifted = bus_rdata >> {lane_q, 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'b0, shifted[7:0]};
            3'b101:  load_ext = {16'b0, shifted[15:0]};
            default: load_ext = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cycle_count <= 8'd0;
            load_data   <= 32'd0;
            bus_valid   <= 1'b0;
            bus_we      <= 1'b0;
            bus_be      <= 4'd0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 32'd0;
            bus_error   <= 1'b0;
            f3_q        <= 3'd0;
            lane_q      <= 2'd0;
            is_load_q   <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= BUS;
                        cycle_count <= 8'd0;
                        bus_valid   <= 1'b1;
                        bus_we      <= req_write;
                        bus_addr    <= {req_addr[31:2], 2'b00};
                        bus_be      <= req_write ? store_be : 4'b1111;
                        bus_wdata   <= req_write ? store_data : 32'd0;
                        f3_q        <= req_f3;
                        lane_q      <= req_addr[1:0];
                        is_load_q   <= !req_write;
                    end
                end
                BUS: begin
                    // A ready on the final counted cycle still wins over the timeout.
                    if (bus_ready) begin
                        state     <= DONE;
                        bus_valid <= 1'b0;
                        if (is_load_q) load_data <= load_ext;
                    end else begin
                        cycle_count <= next_count;
                        if (next_count == TIMEOUT_COUNT) begin
                            state     <= DONE;
                            bus_valid <= 1'b0;
                            bus_error <= 1'b1;
                            if (is_load_q) load_data <= 32'd0;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// transactions compared every cycle against a transaction-level model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_read, req_write;
    logic [2:0]  req_f3;
    logic [31:0] req_addr, req_wdata;
    logic        stall, misaligned, bus_error;
    logic [31:0] load_data;
    logic        bus_valid, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ready;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_read(req_read), .req_write(req_write), .req_f3(req_f3),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .load_data(load_data), .misaligned(misaligned),
        .bus_error(bus_error), .bus_valid(bus_valid), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
        .bus_ready(bus_ready), .bus_rdata(bus_rdata)
    );

    int checks = 0;
    int errors = 0;

    logic        chkEn = 1'b0;
    logic        misChk, busChk, wdataChk;
    logic        expStall, expMis, expValid, expErr, expWe;
    logic [31:0] expLoad, expAddr, expWdata;
    logic [3:0]  expBe;

    int          stallCount = 0;
    int          validCount = 0;
    int          errCount = 0;
    logic [31:0] seenAddr, seenWdata;
    logic [3:0]  seenBe;
    logic        seenWe;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic misalignedOf(input logic [2:0] f3, input logic [31:0] addr);
        if (f3[1:0] == 2'b01) return addr % 2 != 0;
        if (f3[1:0] == 2'b10) return addr % 4 != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] storeBe(input logic [2:0] f3, input logic [1:0] lane);
        if (f3[1:0] == 2'b00) return 4'(1 << lane);
        if (f3[1:0] == 2'b01) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] storeData(input logic [2:0] f3, input logic [31:0] w);
        if (f3[1:0] == 2'b00) return (w & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (w & 32'hFFFF) * 32'h0001_0001;
        return w;
    endfunction

    function automatic logic [31:0] loadExt(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'((word >> (8 * lane)) & 32'hFF);
        h = 16'((word >> (8 * lane)) & 32'hFFFF);
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b100:  return 32'(b);
            3'b101:  return 32'(h);
            default: return word;
        endcase
    endfunction

    // Compare process: sample 3ns after the falling edge, well clear of the rising edge.
    always begin
        @(negedge clk);
        #3;
        if (chkEn) begin
            checkOutput("stall", 32'(stall), 32'(expStall));
            checkOutput("bus_valid", 32'(bus_valid), 32'(expValid));
            checkOutput("bus_error", 32'(bus_error), 32'(expErr));
            checkOutput("load_data", load_data, expLoad);
            if (misChk) checkOutput("misaligned", 32'(misaligned), 32'(expMis));
            if (busChk) begin
                checkOutput("bus_we", 32'(bus_we), 32'(expWe));
                checkOutput("bus_addr", bus_addr, expAddr);
                checkOutput("bus_be", 32'(bus_be), 32'(expBe));
            end
            if (wdataChk) checkOutput("bus_wdata", bus_wdata, expWdata);
        end
        if (stall) stallCount++;
        if (bus_error) errCount++;
        if (bus_valid) begin
            validCount++;
            seenAddr  = bus_addr;
            seenBe    = bus_be;
            seenWe    = bus_we;
            seenWdata = bus_wdata;
        end
    end

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            req_read  = 1'b0;
            req_write = 1'b0;
            bus_ready = 1'($urandom_range(0, 1));
            bus_rdata = $urandom;
            expStall = 1'b0; expValid = 1'b0; expErr = 1'b0;
            misChk = 1'b0; busChk = 1'b0; wdataChk = 1'b0;
        end
    endtask

    // One instruction: IDLE cycle, BUS cycles until ready or timeout, then DONE.
    // waits >= TMO means bus_ready never comes.
    task automatic applyStimulus(input logic isWrite, input logic both, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input int waits, input logic [31:0] rdata);
        logic       mis, tmo;
        int         nBus;
        logic [1:0] lane;
        lane = addr[1:0];
        mis  = misalignedOf(f3, addr);
        tmo  = (waits >= TMO);
        nBus = tmo ? TMO : waits + 1;

        @(negedge clk);
        req_read  = !isWrite || both;
        req_write = isWrite;
        req_f3    = f3;
        req_addr  = addr;
        req_wdata = wdata;
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        expStall = !mis; expMis = mis; misChk = 1'b1;
        expValid = 1'b0; expErr = 1'b0; busChk = 1'b0; wdataChk = 1'b0;
        if (mis) return;

        for (int k = 1; k <= nBus; k++) begin
            @(negedge clk);
            bus_ready = !tmo && (k == nBus);
            bus_rdata = (k == nBus) ? rdata : $urandom;
            expStall = 1'b1; expMis = 1'b0; expValid = 1'b1; expErr = 1'b0;
            busChk = 1'b1; expWe = isWrite;
            expAddr = addr & 32'hFFFF_FFFC;
            expBe = isWrite ? storeBe(f3, lane) : 4'hF;
            wdataChk = isWrite;
            expWdata = storeData(f3, wdata);
        end

        @(negedge clk);
        bus_ready = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        expStall = 1'b0; expMis = 1'b0; expValid = 1'b0; expErr = tmo;
        busChk = 1'b0; wdataChk = 1'b0;
        if (!isWrite) expLoad = tmo ? 32'd0 : loadExt(rdata, f3, lane);
    endtask

    task automatic clearMonitors();
        stallCount = 0; validCount = 0; errCount = 0;
    endtask

    initial begin
        rst = 1'b1; req_read = 1'b0; req_write = 1'b0; req_f3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; bus_ready = 1'b0; bus_rdata = 32'd0;
        misChk = 1'b0; busChk = 1'b0; wdataChk = 1'b0;
        expStall = 1'b0; expMis = 1'b0; expValid = 1'b0; expErr = 1'b0; expWe = 1'b0;
        expLoad = 32'd0; expAddr = 32'd0; expWdata = 32'd0; expBe = 4'd0;

        // Reset values, observed while reset is still held.
        repeat (2) @(negedge clk);
        busChk = 1'b1; wdataChk = 1'b1; chkEn = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idleCycles(2);
        #4;

        // Reset in the second BUS cycle of a store, followed by a stray ready.
        clearMonitors();
        @(negedge clk);
        req_write = 1'b1; req_read = 1'b0; req_f3 = 3'b010;
        req_addr = 32'h40; req_wdata = 32'hCAFE_F00D; bus_ready = 1'b0;
        expStall = 1'b1; expValid = 1'b0; misChk = 1'b1; expMis = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b1;
            expStall = 1'b1; expValid = 1'b1; busChk = 1'b1; expWe = 1'b1;
            expAddr = 32'h40; expBe = 4'hF; wdataChk = 1'b1; expWdata = 32'hCAFE_F00D;
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            rst = 1'b0; req_write = 1'b0; bus_ready = 1'b1;
            expStall = 1'b0; expValid = 1'b0; expErr = 1'b0; misChk = 1'b0;
            expWe = 1'b0; expAddr = 32'd0; expBe = 4'd0; expWdata = 32'd0; expLoad = 32'd0;
        end
        #4;
        checkOutput("rst_valid_cycles", 32'(validCount), 32'd2);
        checkOutput("rst_no_error", 32'(errCount), 32'd0);

        // LB 0x103 with two wait states.
        clearMonitors();
        applyStimulus(1'b0, 1'b0, 3'b000, 32'h103, 32'd0, 2, 32'h80FF_1234);
        idleCycles(1);
        #4;
        checkOutput("lb_load_data", load_data, 32'hFFFF_FF80);
        checkOutput("lb_stall_cycles", 32'(stallCount), 32'd4);
        checkOutput("lb_bus_addr", seenAddr, 32'h100);
        checkOutput("lb_bus_be", 32'(seenBe), 32'hF);

        // SH 0x42, zero wait.
        clearMonitors();
        applyStimulus(1'b1, 1'b0, 3'b001, 32'h42, 32'h0000_BEEF, 0, 32'hDEAD_DEAD);
        idleCycles(1);
        #4;
        checkOutput("sh_bus_we", 32'(seenWe), 32'd1);
        checkOutput("sh_bus_be", 32'(seenBe), 32'hC);
        checkOutput("sh_bus_wdata", seenWdata, 32'hBEEF_BEEF);
        checkOutput("sh_load_kept", load_data, 32'hFFFF_FF80);
        checkOutput("sh_stall_cycles", 32'(stallCount), 32'd2);

        // Misaligned LW 0x6.
        clearMonitors();
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h6, 32'd0, 0, 32'd0);
        idleCycles(1);
        #4;
        checkOutput("lw_mis_valid", 32'(validCount), 32'd0);
        checkOutput("lw_mis_stall", 32'(stallCount), 32'd0);

        // LHU 0x2 with no ready: timeout.
        clearMonitors();
        applyStimulus(1'b0, 1'b0, 3'b101, 32'h2, 32'd0, TMO, 32'd0);
        idleCycles(1);
        #4;
        checkOutput("tmo_valid_cycles", 32'(validCount), 32'd4);
        checkOutput("tmo_error_pulses", 32'(errCount), 32'd1);
        checkOutput("tmo_load_data", load_data, 32'd0);

        // Request held through DONE issues exactly one transaction.
        clearMonitors();
        applyStimulus(1'b0, 1'b0, 3'b010, 32'h10, 32'd0, 0, 32'h1234_5678);
        idleCycles(1);
        #4;
        checkOutput("held_one_txn", 32'(validCount), 32'd1);
        checkOutput("held_load_data", load_data, 32'h1234_5678);

        // Randomized traffic.
        for (int n = 0; n < 200; n++) begin
            logic       isW, both;
            logic [2:0] f3;
            isW  = 1'($urandom_range(0, 1));
            both = isW && ($urandom_range(0, 3) == 0);
            f3   = isW ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            applyStimulus(isW, both, f3, $urandom, $urandom, $urandom_range(0, 5), $urandom);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 2));
        end
        idleCycles(2);
        #4;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum BUS-state cycles before a transaction is abandoned (range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock, all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_read  input  1  load requested by datapath (MemRead).
REQ-005 SHALL have port req_write  input  1  store requested by datapath (MemWrite).
REQ-006 SHALL have port req_f3  input  3  funct3 of the memory instruction.
REQ-007 SHALL have port req_addr  input  32  effective byte address (ALU result).
REQ-008 SHALL have port req_wdata  input  32  store data (rs2), right-aligned.
REQ-009 SHALL have port stall  output  1  datapath holds PC and suppresses writeback while high.
REQ-010 SHALL have port load_data  output  32  extended load result for register file.
REQ-011 SHALL have port misaligned  output  1  combinational misaligned-access flag.
REQ-012 SHALL have port bus_error  output  1  one-cycle pulse on timeout.
REQ-013 SHALL have ports bus_valid out 1, bus_we out 1, bus_addr out 32, bus_be out 4, bus_wdata out 32  memory-side request.
REQ-014 SHALL have ports bus_ready in 1, bus_rdata in 32  memory-side response.

Function
REQ-015 SHALL implement FSM states IDLE, BUS, DONE.
REQ-016 IDLE: new request = req_read|req_write; if request and not misaligned, latch addr/f3/wdata/type and go to BUS next cycle.
REQ-017 If req_read and req_write both high, SHALL treat as store.
REQ-018 misaligned SHALL be 1 in IDLE when f3[1:0]=01 and addr[0]=1, or f3[1:0]=10 and addr[1:0]!=00; such requests SHALL issue no bus transaction and SHALL not stall.
REQ-019 stall SHALL be high in IDLE when a non-misaligned request is present (combinational), high throughout BUS, and low in DONE.
REQ-020 BUS: bus_valid=1; bus_addr={addr[31:2],2'b00}; bus_we, bus_be, bus_wdata held stable until completion.
REQ-021 Transfer completes on the rising edge where bus_valid and bus_ready are both 1; FSM goes to DONE; bus_valid low from the next cycle.
REQ-022 Store byte enables: SB 0001<<addr[1:0]; SH 0011<<addr[1:0]; SW 1111; bus_wdata: byte replicated x4, half replicated x2, word as-is.
REQ-023 Loads SHALL drive bus_be=1111; on completion load_data SHALL register: LB/LH sign-extended, LBU/LHU zero-extended, LW whole word, lane selected by addr[1:0]; undefined f3 (011,110,111) treated as word.
REQ-024 load_data SHALL hold its value until the next completed load or timeout; stores SHALL not change it.
REQ-025 An 8-bit cycle counter SHALL clear on BUS entry and increment each BUS cycle without bus_ready; on reaching TIMEOUT_CYCLES SHALL drop bus_valid, go to DONE, set load_data=0 (loads only), and pulse bus_error during DONE.
REQ-026 bus_ready arriving on the same edge the count reaches TIMEOUT_CYCLES SHALL count as success, no bus_error.
REQ-027 DONE SHALL last exactly one cycle, ignore the still-present request (prevents re-issue), and return to IDLE.
REQ-028 bus_ready while not in BUS SHALL be ignored.
REQ-029 Minimum load/store latency: stall high 2 cycles (IDLE, one BUS cycle) with zero-wait bus.

Reset
REQ-030 With rst high at a rising edge: state=IDLE, counter=0, load_data=0, bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, bus_error=0.
REQ-031 Reset mid-transaction SHALL abandon it immediately without completion or bus_error; any later bus_ready ignored.

Verification
REQ-032 LB addr 0x103, bus_rdata 0x80FF_1234, ready after 2 wait cycles -> bus_addr 0x100, be 1111, load_data 0xFFFF_FF80, stall high 4 cycles.
REQ-033 SH addr 0x42, wdata 0x0000_BEEF, zero-wait -> bus_we 1, be 1100, bus_wdata 0xBEEF_BEEF, load_data unchanged.
REQ-034 LW addr 0x6 -> misaligned 1, stall 0, bus_valid never asserted.
REQ-035 LHU addr 0x2, bus_ready never asserted, TIMEOUT_CYCLES=4 -> bus_valid drops after 4 BUS cycles, bus_error one cycle, load_data 0.
REQ-036 rst asserted in second BUS cycle of a store, then bus_ready -> IDLE, bus_valid 0 next cycle, no DONE, no bus_error.
REQ-037 Request held through DONE (single-cycle datapath) -> exactly one bus transaction per instruction; new request accepted only after IDLE re-entry.
